// File: rtl/draw_region.sv
// draw_region: accepts one rectangle command per valid/ready handshake,
// clips it to the screen, starts the pixel writer over the clipped region
// and supplies the new colour for each pixel the writer visits.
//
// Ports:
//   clock, reset               posedge clock, async active-high reset
//   cmd_valid / cmd_ready      command handshake (ready only when idle)
//   cmd_x/y/w/h, cmd_colour    rectangle origin, size and draw colour
//   cmd_mode                   0 FILL, 1 XOR, 2 CHECKER, 3 BORDER
//   busy, done                 command in progress / 1-cycle completion pulse
//   screen_start               1-cycle writer start pulse
//   screen_x_min/y_min/x_range/y_range   clipped region for the writer
//   screen_x/y, old_screen_colour        pixel being written and its colour
//   new_screen_colour          colour to write (combinational)
//   screen_done                writer finished the region
module draw_region #(
  parameter int WIDTH       = 16,
  parameter int COLOUR_BITS = 3,
  parameter int SCREEN_W    = 320,
  parameter int SCREEN_H    = 240,
  parameter int CHECK_SHIFT = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [WIDTH-1:0]       cmd_x,
  input  logic [WIDTH-1:0]       cmd_y,
  input  logic [WIDTH-1:0]       cmd_w,
  input  logic [WIDTH-1:0]       cmd_h,
  input  logic [COLOUR_BITS-1:0] cmd_colour,
  input  logic [1:0]             cmd_mode,
  output logic                   busy,
  output logic                   done,
  output logic                   screen_start,
  output logic [WIDTH-1:0]       screen_x_min,
  output logic [WIDTH-1:0]       screen_y_min,
  output logic [WIDTH-1:0]       screen_x_range,
  output logic [WIDTH-1:0]       screen_y_range,
  input  logic [WIDTH-1:0]       screen_x,
  input  logic [WIDTH-1:0]       screen_y,
  input  logic [COLOUR_BITS-1:0] old_screen_colour,
  output logic [COLOUR_BITS-1:0] new_screen_colour,
  input  logic                   screen_done
);

  localparam logic [1:0] M_FILL = 2'd0, M_XOR = 2'd1, M_CHECKER = 2'd2, M_BORDER = 2'd3;
  localparam logic [WIDTH:0] SW_EXT = (WIDTH+1)'(SCREEN_W);
  localparam logic [WIDTH:0] SH_EXT = (WIDTH+1)'(SCREEN_H);

  typedef enum logic [1:0] {S_IDLE, S_CLIP, S_START, S_WAIT} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]       lx, ly, lw, lh;
  logic [COLOUR_BITS-1:0] lcol;
  logic [1:0]             lmode;

  // Clip at WIDTH+1 bits so origin+size never wraps.
  logic [WIDTH:0]   sum_x, sum_y, end_x, end_y;
  logic [WIDTH-1:0] rng_x, rng_y;
  logic             empty;

  always_comb begin
    sum_x = {1'b0, lx} + {1'b0, lw};
    sum_y = {1'b0, ly} + {1'b0, lh};
    end_x = (sum_x > SW_EXT) ? SW_EXT : sum_x;
    end_y = (sum_y > SH_EXT) ? SH_EXT : sum_y;
    rng_x = WIDTH'(end_x - {1'b0, lx});
    rng_y = WIDTH'(end_y - {1'b0, ly});
    empty = ({1'b0, lx} >= SW_EXT) || ({1'b0, ly} >= SH_EXT) ||
            (lw == '0) || (lh == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cmd_ready    = 1'b0;
    busy         = 1'b1;
    screen_start = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nxt = S_CLIP;
      end
      S_CLIP:  state_nxt = empty ? S_IDLE : S_START;
      S_START: begin
        screen_start = 1'b1;
        state_nxt    = S_WAIT;
      end
      S_WAIT:  if (screen_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lx <= '0; ly <= '0; lw <= '0; lh <= '0;
      lcol <= '0; lmode <= '0;
      screen_x_min <= '0; screen_y_min <= '0;
      screen_x_range <= '0; screen_y_range <= '0;
      done <= 1'b0;
    end else begin
      // done lands in the cycle the FSM is back in IDLE, so ready and done coincide.
      done <= ((state == S_CLIP) && empty) || ((state == S_WAIT) && screen_done);
      if ((state == S_IDLE) && cmd_valid) begin
        lx <= cmd_x; ly <= cmd_y; lw <= cmd_w; lh <= cmd_h;
        lcol <= cmd_colour; lmode <= cmd_mode;
      end
      if ((state == S_CLIP) && !empty) begin
        screen_x_min   <= lx;
        screen_y_min   <= ly;
        screen_x_range <= rng_x;
        screen_y_range <= rng_y;
      end
    end
  end

  // Pixel colour
  logic [WIDTH-1:0] x_last, y_last, cell_x, cell_y;
  logic             on_edge, cell_odd;

  always_comb begin
    x_last   = screen_x_min + screen_x_range - WIDTH'(1);
    y_last   = screen_y_min + screen_y_range - WIDTH'(1);
    on_edge  = (screen_x == screen_x_min) || (screen_x == x_last) ||
               (screen_y == screen_y_min) || (screen_y == y_last);
    cell_x   = screen_x >> CHECK_SHIFT;
    cell_y   = screen_y >> CHECK_SHIFT;
    cell_odd = cell_x[0] ^ cell_y[0];
    new_screen_colour = lcol;
    case (lmode)
      M_FILL:    new_screen_colour = lcol;
      M_XOR:     new_screen_colour = old_screen_colour ^ lcol;
      M_CHECKER: new_screen_colour = cell_odd ? old_screen_colour : lcol;
      M_BORDER:  new_screen_colour = on_edge ? lcol : old_screen_colour;
      default:   new_screen_colour = lcol;
    endcase
  end

endmodule

// File: tb/tb_draw_region.sv
module tb_draw_region;

  localparam int SW = 320, SH = 240;

  logic        clock = 1'b0, reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [15:0] cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [2:0]  cmd_colour = '0;
  logic [1:0]  cmd_mode = '0;
  logic        busy, done, screen_start;
  logic [15:0] screen_x_min, screen_y_min, screen_x_range, screen_y_range;
  logic [15:0] screen_x = '0, screen_y = '0;
  logic [2:0]  old_screen_colour = '0, new_screen_colour;
  logic        screen_done = 1'b0;

  draw_region dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_colour(cmd_colour), .cmd_mode(cmd_mode), .busy(busy), .done(done),
    .screen_start(screen_start), .screen_x_min(screen_x_min), .screen_y_min(screen_y_min),
    .screen_x_range(screen_x_range), .screen_y_range(screen_y_range),
    .screen_x(screen_x), .screen_y(screen_y), .old_screen_colour(old_screen_colour),
    .new_screen_colour(new_screen_colour), .screen_done(screen_done)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;
  logic [2:0] fb     [0:SH-1][0:SW-1];  // screen written through the DUT
  logic [2:0] ref_fb [0:SH-1][0:SW-1];  // screen predicted by the model

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: clip and per-pixel colour straight from the rules.
  function automatic void clip(input int x, y, w, h, output bit ne, output int xr, yr);
    ne = !(x >= SW || y >= SH || w == 0 || h == 0);
    xr = ((x + w > SW) ? SW : x + w) - x;
    yr = ((y + h > SH) ? SH : y + h) - y;
  endfunction

  function automatic int ref_col(input int mode, c, x, y, o, xm, ym, xr, yr);
    case (mode)
      0: return c;
      1: return o ^ c;
      2: return (((x / 8) + (y / 8)) % 2 == 0) ? c : o;
      default: return (x == xm || x == xm + xr - 1 || y == ym || y == ym + yr - 1) ? c : o;
    endcase
  endfunction

  task automatic cmp_fb();
    int diffs = 0;
    for (int yy = 0; yy < SH; yy++)
      for (int xx = 0; xx < SW; xx++)
        if (fb[yy][xx] !== ref_fb[yy][xx]) diffs++;
    chk("framebuffer", diffs, 0);
  endtask

  // Issues a command, plays the pixel writer over the expected region and
  // checks handshake timing, region outputs and the resulting screen.
  task automatic run_cmd(input int x, y, w, h, col, mode,
                         input bit es, input int exm, eym, exr, eyr);
    int bad_done = 0;
    chk("ready_idle", int'(cmd_ready), 1);
    cmd_x = 16'(x); cmd_y = 16'(y); cmd_w = 16'(w); cmd_h = 16'(h);
    cmd_colour = 3'(col); cmd_mode = 2'(mode); cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    cmd_x = 16'($urandom); cmd_y = 16'($urandom); cmd_w = 16'($urandom);
    cmd_h = 16'($urandom); cmd_colour = 3'($urandom); cmd_mode = 2'($urandom);
    screen_done = 1'b1;  // stray pulse outside WAIT
    chk("clip_busy", int'({busy, screen_start, cmd_ready, done}), 8);
    @(posedge clock); #1;
    screen_done = 1'b0;
    if (!es) begin
      chk("empty_done", int'({done, screen_start, cmd_ready, busy}), 10);
      @(posedge clock); #1;
      chk("empty_done_once", int'({done, screen_start}), 0);
      cmp_fb();
      return;
    end
    chk("start_latency", int'({screen_start, done, cmd_ready}), 4);
    chk("region_x_min", int'(screen_x_min), exm);
    chk("region_y_min", int'(screen_y_min), eym);
    chk("region_x_range", int'(screen_x_range), exr);
    chk("region_y_range", int'(screen_y_range), eyr);
    for (int yy = eym; yy < eym + eyr; yy++)
      for (int xx = exm; xx < exm + exr; xx++)
        ref_fb[yy][xx] = 3'(ref_col(mode, col, xx, yy, int'(ref_fb[yy][xx]), exm, eym, exr, eyr));
    @(posedge clock); #1;
    chk("start_one_cycle", int'(screen_start), 0);
    for (int yy = eym; yy < eym + eyr; yy++)
      for (int xx = exm; xx < exm + exr; xx++) begin
        screen_x = 16'(xx); screen_y = 16'(yy); old_screen_colour = fb[yy][xx];
        @(negedge clock);
        fb[yy][xx] = new_screen_colour;
        if (done || !busy) bad_done++;
        @(posedge clock); #1;
      end
    chk("wait_busy_no_done", bad_done, 0);
    screen_done = 1'b1;
    @(posedge clock); #1;
    screen_done = 1'b0;
    chk("done_pulse", int'({done, cmd_ready, busy}), 6);
    cmp_fb();
    @(posedge clock); #1;
    chk("done_once", int'(done), 0);
  endtask

  typedef struct {
    int x, y, w, h, col, mode;
    bit es; int exm, eym, exr, eyr;
    bit ck; int cx, cy, cv;
  } vec_t;
  vec_t tbl [13];

  initial begin
    int n6;
    for (int yy = 0; yy < SH; yy++)
      for (int xx = 0; xx < SW; xx++) begin fb[yy][xx] = '0; ref_fb[yy][xx] = '0; end

    tbl[0]  = '{10, 20, 5, 4, 3, 0,  1, 10, 20, 5, 4,  1, 12, 22, 3};
    tbl[1]  = '{318, 238, 10, 10, 2, 0,  1, 318, 238, 2, 2,  1, 319, 239, 2};
    tbl[2]  = '{400, 0, 5, 5, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0};
    tbl[3]  = '{5, 5, 0, 5, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0};
    tbl[4]  = '{5, 240, 5, 5, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0};
    tbl[5]  = '{40, 40, 6, 3, 5, 0,  1, 40, 40, 6, 3,  1, 45, 42, 5};
    tbl[6]  = '{40, 40, 6, 3, 7, 1,  1, 40, 40, 6, 3,  1, 40, 40, 2};
    tbl[7]  = '{40, 40, 6, 3, 7, 1,  1, 40, 40, 6, 3,  1, 43, 41, 5};
    tbl[8]  = '{0, 0, 16, 16, 1, 2,  1, 0, 0, 16, 16,  1, 0, 0, 1};
    tbl[9]  = '{100, 100, 4, 3, 6, 3,  1, 100, 100, 4, 3,  1, 101, 101, 0};
    tbl[10] = '{200, 50, 1, 5, 4, 3,  1, 200, 50, 1, 5,  1, 200, 52, 4};
    tbl[11] = '{300, 230, 65535, 65520, 1, 1,  1, 300, 230, 20, 10,  1, 319, 239, 3};
    tbl[12] = '{60, 60, 2, 2, 5, 0,  1, 60, 60, 2, 2,  1, 61, 61, 5};

    // Reset state
    #12;
    chk("rst_outputs", int'({cmd_ready, busy, done, screen_start}), 8);
    chk("rst_region", int'(screen_x_min | screen_y_min | screen_x_range | screen_y_range), 0);
    chk("rst_colour", int'(new_screen_colour), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    foreach (tbl[i]) begin
      run_cmd(tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].col, tbl[i].mode,
              tbl[i].es, tbl[i].exm, tbl[i].eym, tbl[i].exr, tbl[i].eyr);
      if (tbl[i].ck) chk($sformatf("pixel_%0d", i), int'(fb[tbl[i].cy][tbl[i].cx]), tbl[i].cv);
    end
    chk("checker_8_0", int'(fb[0][8]), 0);
    chk("checker_8_8", int'(fb[8][8]), 1);
    n6 = 0;
    for (int yy = 100; yy < 103; yy++)
      for (int xx = 100; xx < 104; xx++) if (fb[yy][xx] == 3'd6) n6++;
    chk("border_edge_count", n6, 10);

    // Reset while waiting for the writer
    cmd_x = 16'd70; cmd_y = 16'd70; cmd_w = 16'd3; cmd_h = 16'd3;
    cmd_colour = 3'd7; cmd_mode = 2'd0; cmd_valid = 1'b1;
    @(posedge clock); #1; cmd_valid = 1'b0;
    @(posedge clock); #1;
    chk("abort_start", int'(screen_start), 1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("abort_in_wait", int'({busy, cmd_ready}), 2);
    reset = 1'b1; #1;
    chk("abort_async", int'({cmd_ready, busy, screen_start, done}), 8);
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort_idle", int'({cmd_ready, busy, done}), 4);
    chk("abort_region", int'(screen_x_range), 0);
    @(posedge clock); #1;
    chk("abort_no_done", int'(done), 0);
    run_cmd(70, 70, 3, 3, 7, 0, 1, 70, 70, 3, 3);

    // Random commands against the model
    for (int k = 0; k < 20; k++) begin
      int x, y, w, h, xr, yr; bit ne;
      x = $urandom_range(0, 330); y = $urandom_range(0, 250);
      w = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 20);
      h = $urandom_range(0, 20);
      clip(x, y, w, h, ne, xr, yr);
      run_cmd(x, y, w, h, $urandom_range(0, 7), $urandom_range(0, 3), ne, x, y, xr, yr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
